// File: rtl/openddr_refresh_ctrl.sv
`timescale 1ns/1ps
// Auto-refresh sequencer: tREFI tick generation, owed-refresh accounting and the
// PREA/REF command sequence issued while the scheduler's bus grant is held.
//
// state       | meaning
// ------------+------------------------------------------------------------
// ST_IDLE     | no sequence; waiting for owed refreshes and an opportunity
// ST_REQ      | ref_req high, waiting for ref_gnt
// ST_PREA     | PREA presented on the command bus until cmd_ready
// ST_WAIT_RP  | tRP countdown after the accepted PREA
// ST_REF      | REF presented on the command bus until cmd_ready
// ST_WAIT_RFC | tRFC countdown; ref_done on the terminal cycle
module openddr_refresh_ctrl #(
    parameter int MAX_PEND = 8,
    parameter int TREFI_W  = 16,
    parameter int TRFC_W   = 10,
    localparam int PEND_W  = $clog2(MAX_PEND + 1)
) (
    input  logic               mck,
    input  logic               mc_rst_b,
    input  logic               cfg_ref_en,
    input  logic [TREFI_W-1:0] cfg_trefi,
    input  logic [5:0]         cfg_trp,
    input  logic [TRFC_W-1:0]  cfg_trfc,
    input  logic [3:0]         cfg_postpone,
    input  logic               sched_idle,
    input  logic               banks_open,
    output logic               ref_req,
    input  logic               ref_gnt,
    output logic               ref_urgent,
    output logic               cmd_valid,
    output logic               cmd_is_ref,
    input  logic               cmd_ready,
    output logic [PEND_W-1:0]  pend_cnt,
    output logic               ref_done,
    output logic               ref_overflow
);
    localparam int WAIT_W = (TRFC_W > 6) ? TRFC_W : 6;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_REQ      = 3'd1;
    localparam logic [2:0] ST_PREA     = 3'd2;
    localparam logic [2:0] ST_WAIT_RP  = 3'd3;
    localparam logic [2:0] ST_REF      = 3'd4;
    localparam logic [2:0] ST_WAIT_RFC = 3'd5;

    logic [2:0]         state_q, state_d;
    logic [TREFI_W-1:0] trefi_cnt_q, trefi_cnt_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [PEND_W-1:0]  pend_cnt_q, pend_cnt_d;
    logic               ovf_q, ovf_d;
    logic               req_q, req_d;
    logic               drain_q, drain_d;
    logic               tick;
    logic               cnt_en;
    logic               ref_done_c;
    logic               urgent_c;
    logic               chain_ref;
    logic [3:0]         postpone_eff;

    assign cnt_en       = cfg_ref_en && (cfg_trefi != '0);
    assign postpone_eff = (cfg_postpone == 4'd0) ? 4'd1 : cfg_postpone;
    assign urgent_c     = (32'(pend_cnt_q) >= 32'(postpone_eff));
    assign ref_done_c   = (state_q == ST_WAIT_RFC) && (wait_cnt_q == '0);
    // Once escalated, keep draining under the same grant until one refresh is left.
    assign chain_ref    = (pend_cnt_q > PEND_W'(1)) && (drain_q || urgent_c);

    // Counter starts at 0 so the first enabled cycle loads cfg_trefi without a tick.
    always_comb begin
        trefi_cnt_d = trefi_cnt_q;
        tick        = 1'b0;
        if (cnt_en) begin
            if (trefi_cnt_q <= TREFI_W'(1)) begin
                trefi_cnt_d = cfg_trefi;
                tick        = (trefi_cnt_q == TREFI_W'(1));
            end else begin
                trefi_cnt_d = trefi_cnt_q - TREFI_W'(1);
            end
        end
    end

    always_comb begin
        pend_cnt_d = pend_cnt_q;
        ovf_d      = ovf_q;
        case ({tick, ref_done_c})
            2'b10: begin
                if (pend_cnt_q == PEND_W'(MAX_PEND)) begin
                    ovf_d = 1'b1;
                end else begin
                    pend_cnt_d = pend_cnt_q + PEND_W'(1);
                end
            end
            2'b01: begin
                if (pend_cnt_q != '0) begin
                    pend_cnt_d = pend_cnt_q - PEND_W'(1);
                end
            end
            default: pend_cnt_d = pend_cnt_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        req_d      = req_q;
        case (state_q)
            ST_IDLE: begin
                if ((pend_cnt_q != '0) && (sched_idle || urgent_c)) begin
                    state_d = ST_REQ;
                    req_d   = 1'b1;
                end
            end
            ST_REQ: begin
                if (ref_gnt) begin
                    state_d = banks_open ? ST_PREA : ST_REF;
                end
            end
            ST_PREA: begin
                if (cmd_ready) begin
                    if (cfg_trp == 6'd0) begin
                        state_d = ST_REF;
                    end else begin
                        wait_cnt_d = WAIT_W'(cfg_trp);
                        state_d    = ST_WAIT_RP;
                    end
                end
            end
            ST_WAIT_RP: begin
                if (wait_cnt_q <= WAIT_W'(1)) begin
                    state_d = ST_REF;
                end else begin
                    wait_cnt_d = wait_cnt_q - WAIT_W'(1);
                end
            end
            ST_REF: begin
                if (cmd_ready) begin
                    wait_cnt_d = WAIT_W'(cfg_trfc);
                    state_d    = ST_WAIT_RFC;
                end
            end
            ST_WAIT_RFC: begin
                if (wait_cnt_q == '0) begin
                    if (chain_ref) begin
                        state_d = ST_REF;
                    end else begin
                        state_d = ST_IDLE;
                        req_d   = 1'b0;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q - WAIT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
        drain_d = (state_d != ST_IDLE) && (drain_q || urgent_c);
    end

    always_ff @(posedge mck or negedge mc_rst_b) begin
        if (!mc_rst_b) begin
            state_q     <= ST_IDLE;
            trefi_cnt_q <= '0;
            wait_cnt_q  <= '0;
            pend_cnt_q  <= '0;
            ovf_q       <= 1'b0;
            req_q       <= 1'b0;
            drain_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            trefi_cnt_q <= trefi_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            pend_cnt_q  <= pend_cnt_d;
            ovf_q       <= ovf_d;
            req_q       <= req_d;
            drain_q     <= drain_d;
        end
    end

    assign ref_req      = req_q;
    assign ref_urgent   = urgent_c;
    assign cmd_valid    = (state_q == ST_PREA) || (state_q == ST_REF);
    assign cmd_is_ref   = (state_q == ST_REF);
    assign pend_cnt     = pend_cnt_q;
    assign ref_done     = ref_done_c;
    assign ref_overflow = ovf_q;

endmodule
